led_bar_sequencer: RTL and testbench

//   Controller in front of the 8-LED bar-graph driver: debounces the raw board switches and
//   a mode button, and produces the driver's 4-bit command {level[2:0], blank}.

---
 rtl/led_bar_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_led_bar_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bar_sequencer.sv
// ---------------------------------------------------------------------------
// led_bar_sequencer
//   Front-end controller for the 8-LED bar-graph driver. It debounces the raw
//   board switches and the mode button, then produces the driver command
//   {level[2:0], blank}.
//     MANUAL : level follows the debounced switches sw[3:1].
//     SWEEP  : level ping-pongs 0..7..0, one step every STEP_CYCLES cycles
//              (states UP and DOWN).
//   A debounced rising edge of the button toggles between MANUAL and SWEEP.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   sw_raw      raw switches; [3:1] = manual level, [0] = blank request
//   btn_raw     raw mode button
//   bar_code    {level[2:0], blank} to the bar-graph driver (registered)
//   mode_sweep  0 = MANUAL, 1 = SWEEP (registered with the state)
//   step_pulse  one-cycle strobe on every sweep step (registered)
// ---------------------------------------------------------------------------
module led_bar_sequencer #(
  parameter int DEB_CYCLES  = 20,
  parameter int STEP_CYCLES = 50,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_raw,
  input  logic       btn_raw,
  output logic [3:0] bar_code,
  output logic       mode_sweep,
  output logic       step_pulse
);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    UP     = 2'd1,
    DOWN   = 2'd2
  } state_t;

  localparam int             NB        = 5;
  // Debounced blank starts asserted so the bar stays dark until the
  // switches have been qualified.
  localparam logic [NB-1:0]  DEB_RST   = 5'b00001;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

  // Bit layout of the debounced bundle: [4] = button, [3:0] = switches.
  logic [NB-1:0] raw_all;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] deb;

  assign raw_all = {btn_raw, sw_raw};

  // Two-flop synchroniser for the asynchronous board inputs.
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample pre-edge values; blocking here would collapse sync1/sync2 into
  // one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_all;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: the output only follows the synchronised input after
  // it has disagreed for DEB_CYCLES consecutive cycles.
  for (genvar i = 0; i < NB; i++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             deb_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt   <= '0;
        deb_q <= DEB_RST[i];
      end else if (sync2[i] == deb_q) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        deb_q <= sync2[i];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign deb[i] = deb_q;
  end

  logic btn_d1;
  logic btn_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_d1 <= 1'b0;
    else     btn_d1 <= deb[4];
  end

  assign btn_rise = deb[4] & ~btn_d1;

  // Mode FSM and level/step datapath.
  state_t           state;
  state_t           state_n;
  logic [2:0]       level;
  logic [2:0]       level_n;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] step_cnt_n;
  logic             step_pulse_n;
  logic             blank;

  // NOTE: all architectural state, including the counters, is reset so a
  // reset in the middle of a sweep leaves nothing behind (no stray pulse).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= MANUAL;
      level      <= 3'd0;
      step_cnt   <= '0;
      step_pulse <= 1'b0;
      mode_sweep <= 1'b0;
      blank      <= 1'b1;
    end else begin
      state      <= state_n;
      level      <= level_n;
      step_cnt   <= step_cnt_n;
      step_pulse <= step_pulse_n;
      mode_sweep <= (state_n != MANUAL);
      blank      <= deb[0];
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n      = state;
    level_n      = level;
    step_cnt_n   = step_cnt;
    step_pulse_n = 1'b0;

    unique case (state)
      MANUAL: begin
        step_cnt_n = '0;
        if (btn_rise) state_n = UP;     // level is held on entry
        else          level_n = deb[3:1];
      end

      UP, DOWN: begin
        if (btn_rise) begin
          // Button beats a coinciding step: no level change, no pulse.
          state_n    = MANUAL;
          step_cnt_n = '0;
        end else if (step_cnt == STEP_LAST) begin
          step_cnt_n   = '0;
          step_pulse_n = 1'b1;
          if (state == UP) begin
            if (level == 3'd7) begin
              state_n = DOWN;
              level_n = 3'd6;
            end else begin
              level_n = level + 3'd1;
            end
          end else begin
            if (level == 3'd0) begin
              state_n = UP;
              level_n = 3'd1;
            end else begin
              level_n = level - 3'd1;
            end
          end
        end else begin
          step_cnt_n = step_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_n    = MANUAL;
        step_cnt_n = '0;
      end
    endcase
  end

  assign bar_code = {level, blank};

endmodule

// File: tb/tb_led_bar_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_bar_sequencer
//   Self-checking bench for led_bar_sequencer with DEB_CYCLES=4 and
//   STEP_CYCLES=5. A cycle-level reference model tracks debounce by counting
//   consecutive disagreeing samples and tracks the sweep as a position on a
//   14-step triangle wave. Directed scenarios are followed by random
//   switch/button activity; outputs are compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_led_bar_sequencer;

  localparam int DEB  = 4;
  localparam int STEP = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw_raw;
  logic       btn_raw;
  logic [3:0] bar_code;
  logic       mode_sweep;
  logic       step_pulse;

  led_bar_sequencer #(
    .DEB_CYCLES (DEB),
    .STEP_CYCLES(STEP),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .btn_raw   (btn_raw),
    .bar_code  (bar_code),
    .mode_sweep(mode_sweep),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ------------------------- reference model -------------------------------
  logic [4:0] m_s1, m_s2, m_deb;
  int         m_run [5];
  logic       m_btn_prev;
  bit         m_sweep;
  int         m_pos;      // position on the 0..13 triangle wave
  int         m_phase;    // cycles since last step / sweep entry
  logic [2:0] m_level;
  logic       m_blank;
  logic       m_pulse;

  function automatic logic [2:0] tri_level(input int pos);
    return (pos <= 7) ? 3'(pos) : 3'(14 - pos);
  endfunction

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_deb = 5'b00001;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    m_btn_prev = 1'b0;
    m_sweep = 1'b0;
    m_pos = 0;
    m_phase = 0;
    m_level = 3'd0;
    m_blank = 1'b1;
    m_pulse = 1'b0;
  endtask

  // Advance the model by one rising edge using the pre-edge values.
  task automatic model_edge();
    logic [4:0] syn;
    logic       rise;
    logic [3:0] dsw;
    syn  = m_s2;
    rise = m_deb[4] & ~m_btn_prev;
    dsw  = m_deb[3:0];

    m_pulse = 1'b0;
    if (!m_sweep) begin
      if (rise) begin
        m_sweep = 1'b1;
        m_pos   = int'(m_level);
        m_phase = 0;
      end else begin
        m_level = dsw[3:1];
      end
    end else if (rise) begin
      m_sweep = 1'b0;
      m_phase = 0;
    end else if (m_phase == STEP - 1) begin
      m_phase = 0;
      m_pulse = 1'b1;
      m_pos   = (m_pos + 1) % 14;
      m_level = tri_level(m_pos);
    end else begin
      m_phase++;
    end
    m_blank    = dsw[0];
    m_btn_prev = m_deb[4];

    for (int i = 0; i < 5; i++) begin
      if (syn[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_deb[i] = syn[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end

    m_s2 = m_s1;
    m_s1 = {btn_raw, sw_raw};
  endtask

  // One clock: model follows the rising edge, outputs compared at the fall.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("bar_code",   8'(bar_code),   8'({m_level, m_blank}));
    check("mode_sweep", 8'(mode_sweep), 8'(m_sweep));
    check("step_pulse", 8'(step_pulse), 8'(m_pulse));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // ------------------------------ stimulus ---------------------------------
  logic [2:0] seq [$];
  logic [2:0] exp_seq [9];
  bit         found;
  int         sw_hold;
  int         btn_hold;

  initial begin
    exp_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};

    // Reset with switches already at 1010.
    rst     = 1'b1;
    sw_raw  = 4'b1010;
    btn_raw = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_bar",   8'(bar_code),   8'h01);
    check("rst_mode",  8'(mode_sweep), 8'h00);
    check("rst_pulse", 8'(step_pulse), 8'h00);
    rst = 1'b0;
    ticks(7);
    check("por_level", 8'(bar_code), 8'h0A);
    ticks(3);

    // Short blank glitch (3 cycles) is rejected.
    sw_raw[0] = 1'b1;
    ticks(3);
    sw_raw[0] = 1'b0;
    ticks(10);
    check("glitch_short", 8'(bar_code[0]), 8'h00);

    // A 4-cycle blank request is accepted, visible at cycle 7.
    sw_raw[0] = 1'b1;
    ticks(4);
    sw_raw[0] = 1'b0;
    ticks(3);
    check("glitch_hold", 8'(bar_code[0]), 8'h01);
    ticks(10);

    // Sweep from level 6 with the button held high.
    sw_raw = 4'b1100;
    ticks(10);
    btn_raw = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c == 30) sw_raw[0] = 1'b1;   // blank mid-sweep must not stall stepping
      tick();
      if (step_pulse === 1'b1 && seq.size() < 9) seq.push_back(bar_code[3:1]);
    end
    check("sweep_count", 8'(seq.size()), 8'd9);
    for (int i = 0; i < 9 && i < seq.size(); i++)
      check($sformatf("sweep_seq%0d", i), 8'(seq[i]), 8'(exp_seq[i]));
    check("sweep_blank", 8'(bar_code[0]), 8'h01);

    // Releasing the button does not toggle the mode.
    btn_raw = 1'b0;
    sw_raw  = 4'b0110;
    ticks(12);
    check("release_mode", 8'(mode_sweep), 8'h01);

    // Align the next press so its debounced edge lands on a step wrap.
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (m_sweep && m_phase == 3) found = 1'b1;
    end
    check("coincide_align", 8'(found), 8'h01);
    btn_raw = 1'b1;
    ticks(7);
    check("coincide_pulse", 8'(step_pulse), 8'h00);
    check("coincide_mode",  8'(mode_sweep), 8'h00);
    tick();
    check("coincide_level", 8'(bar_code[3:1]), 8'd3);

    // Back into sweep, then reset right after a step pulse.
    btn_raw = 1'b0;
    ticks(10);
    btn_raw = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (m_pulse) found = 1'b1;
    end
    check("pre_rst_pulse", 8'(found), 8'h01);
    rst = 1'b1;
    #1;
    check("midrst_bar",   8'(bar_code),   8'h01);
    check("midrst_pulse", 8'(step_pulse), 8'h00);
    check("midrst_mode",  8'(mode_sweep), 8'h00);
    model_reset();
    btn_raw = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ticks(2);

    // Random activity on switches and button.
    sw_hold  = 0;
    btn_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (sw_hold == 0) begin
        sw_raw  = 4'($urandom);
        sw_hold = $urandom_range(1, 12);
      end else begin
        sw_hold--;
      end
      if (btn_hold == 0) begin
        btn_raw  = ~btn_raw;
        btn_hold = $urandom_range(1, 40);
      end else begin
        btn_hold--;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
